// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Issue controller that sits between the control unit/bus and the 32-bit ALU.
//   Takes one operation per request handshake, latches its operands, drives the
//   ALU's one-hot strobe for the op's latency, captures the 64-bit result C
//   into z_hi/z_lo and returns it over a response handshake. Only one
//   operation is in flight at a time.
//
// Ports
//   clk, clr_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_op, req_a, req_b  opcode (0..12 legal) and operands
//   alu_ctl               one-hot ALU strobes, bit n = opcode n
//   alu_a, alu_b          operands presented to the ALU (latched on accept)
//   alu_c                 64-bit ALU result
//   rsp_valid/rsp_ready   response handshake
//   z_hi, z_lo, rsp_err   result halves and error flag (illegal op, DIV by 0)
//   op_count              completed responses, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int LAT_BASE = 1,
  parameter int LAT_MUL  = 1,
  parameter int LAT_DIV  = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [12:0]      alu_ctl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [63:0]      alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      z_hi,
  output logic [31:0]      z_lo,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_LAST = 4'd12;

  localparam int LAT_MAX_BM = (LAT_BASE > LAT_MUL) ? LAT_BASE : LAT_MUL;
  localparam int LAT_MAX    = (LAT_MAX_BM > LAT_DIV) ? LAT_MAX_BM : LAT_DIV;
  localparam int LCW        = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic [LCW-1:0]     lat_cnt_reg;
  logic [31:0]        a_reg, b_reg;
  logic [63:0]        z_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               accept;
  logic               op_legal;

  function automatic logic [LCW-1:0] lat_for(input logic [3:0] op);
    if (op == OP_MUL)      return LCW'(LAT_MUL);
    else if (op == OP_DIV) return LCW'(LAT_DIV);
    else                   return LCW'(LAT_BASE);
  endfunction

  assign op_legal = (req_op <= OP_LAST);
  assign accept   = req_valid && req_ready;

  // state_reg is forced to IDLE asynchronously, so gating with clr_n keeps
  // req_ready low for the whole time reset is held.
  assign req_ready = clr_n && (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);

  // Strobes decode directly from the state register: they drop to zero the
  // moment reset asserts and can only be non-zero (and then one-hot) in ISSUE.
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_strobe
      assign alu_ctl[gi] = (state_reg == S_ISSUE) && (op_reg == 4'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = op_legal ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        if (lat_cnt_reg == LCW'(1)) state_next = S_CAPTURE;
      end
      S_CAPTURE: state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      lat_cnt_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      z_reg       <= '0;
      err_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg      <= req_op;
            a_reg       <= req_a;
            b_reg       <= req_b;
            lat_cnt_reg <= lat_for(req_op);
            // Illegal opcodes skip the ALU entirely and answer with an error.
            if (!op_legal) begin
              z_reg   <= '0;
              err_reg <= 1'b1;
            end
          end
        end
        S_ISSUE: lat_cnt_reg <= lat_cnt_reg - LCW'(1);
        S_CAPTURE: begin
          z_reg   <= alu_c;
          err_reg <= (op_reg == OP_DIV) && (b_reg == 32'd0);
        end
        S_RESP: begin
          if (rsp_ready) count_reg <= count_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign z_hi     = z_reg[63:32];
  assign z_lo     = z_reg[31:0];
  assign rsp_err  = err_reg;
  assign op_count = count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             req_valid, req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [12:0]      alu_ctl;
  logic [31:0]      alu_a, alu_b;
  logic [63:0]      alu_c;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      z_hi, z_lo;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer #(.LAT_BASE(1), .LAT_MUL(3), .LAT_DIV(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .z_hi(z_hi), .z_lo(z_lo), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour (64-bit result of one operation).
  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] aa, bb, dbl, r;
    logic [4:0]  s;
    aa = {32'd0, a};
    bb = {32'd0, b};
    s  = b[4:0];
    dbl = {a, a};
    r = 64'd0;
    case (op)
      4'd0:  r = aa & bb;
      4'd1:  r = aa | bb;
      4'd2:  r = aa + bb;
      4'd3:  r = aa - bb;
      4'd4:  r = aa * bb;
      4'd5:  r = (b == 32'd0) ? 64'd0 : {a % b, a / b};
      4'd6:  r = {32'd0, a >> s};
      4'd7:  r = {32'd0, a << s};
      4'd8:  begin dbl = dbl >> s; r = {32'd0, dbl[31:0]}; end
      4'd9:  begin dbl = dbl << s; r = {32'd0, dbl[63:32]}; end
      4'd10: r = 64'd0 - aa;
      4'd11: r = {32'd0, ~a};
      4'd12: r = {32'd0, a + 32'd1};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    if (op > 4'd12)      return 0;
    else if (op == 4'd4) return 3;
    else if (op == 4'd5) return 2;
    else                 return 1;
  endfunction

  function automatic logic [3:0] ctl_to_op(input logic [12:0] ctl);
    logic [3:0] r;
    r = 4'd15;
    for (int i = 0; i < 13; i++) if (ctl[i]) r = 4'(i);
    return r;
  endfunction

  // Behavioural registered ALU: C updates at the end of every strobe cycle and
  // is scrambled otherwise, so a capture in the wrong cycle shows up.
  int          strobe_total = 0;
  int          bad_ctl      = 0;
  logic [12:0] last_ctl     = 13'd0;
  initial alu_c = 64'hBAD0_BAD0_BAD0_BAD0;
  always @(posedge clk) begin
    if (alu_ctl != 13'd0) begin
      strobe_total <= strobe_total + 1;
      last_ctl     <= alu_ctl;
      if ($countones(alu_ctl) != 1) bad_ctl <= bad_ctl + 1;
      alu_c <= alu_model(ctl_to_op(alu_ctl), alu_a, alu_b);
    end else begin
      alu_c <= 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Scoreboard entry pushed at request time, popped when the response shows up.
  typedef struct {
    logic [63:0] z;
    logic        err;
    int          lat;
    logic [12:0] ctl;
  } exp_t;
  exp_t sb_q[$];
  int   model_cnt = 0;

  function automatic exp_t make_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.lat = exp_lat(op);
    e.err = (op > 4'd12) || (op == 4'd5 && b == 32'd0);
    e.z   = (op > 4'd12) ? 64'd0 : alu_model(op, a, b);
    e.ctl = (op > 4'd12) ? 13'd0 : (13'd1 << op);
    return e;
  endfunction

  // Drives a request and returns just after the accepting edge.
  task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit timeout);
    timeout   = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin timeout = 1'b0; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts edges from acceptance until rsp_valid is visible.
  task automatic wait_rsp(output int cycles, output bit timeout);
    cycles  = 0;
    timeout = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin timeout = 1'b0; break; end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic finish_rsp(input logic keep_ready);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = keep_ready;
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endtask

  // Runs one op end-to-end and compares against the popped scoreboard entry.
  task automatic run_and_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic keep_ready);
    exp_t e;
    bit   to;
    int   cyc, s0, want_cyc;
    s0 = strobe_total;
    send_req(op, a, b, to);
    checks++;
    if (to) begin failures++; $display("FAIL %s accept: req_ready never high", tag); end
    wait_rsp(cyc, to);
    e = sb_q.pop_front();
    want_cyc = (e.lat == 0) ? 0 : e.lat + 1;
    checks++;
    if (to || cyc !== want_cyc) begin
      failures++; $display("FAIL %s latency: got %0d (timeout=%0d) want %0d", tag, cyc, to, want_cyc);
    end
    checks++;
    if ((strobe_total - s0) !== e.lat) begin
      failures++; $display("FAIL %s strobe_cycles: got %0d want %0d", tag, strobe_total - s0, e.lat);
    end
    if (e.lat != 0) begin
      checks++;
      if (last_ctl !== e.ctl) begin
        failures++; $display("FAIL %s alu_ctl: got %h want %h", tag, last_ctl, e.ctl);
      end
    end
    checks++;
    if ({z_hi, z_lo} !== e.z || rsp_err !== e.err) begin
      failures++; $display("FAIL %s result: got z=%h err=%b want z=%h err=%b", tag, {z_hi, z_lo}, rsp_err, e.z, e.err);
    end
    finish_rsp(keep_ready);
    checks++;
    if (op_count !== CNT_W'(model_cnt) || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s post_rsp: op_count=%0d rsp_valid=%b req_ready=%b want %0d/0/1",
                           tag, op_count, rsp_valid, req_ready, model_cnt);
    end
    $display("op %s op=%0d a=%h b=%h z=%h err=%b count=%0d", tag, op, a, b, {z_hi, z_lo}, rsp_err, op_count);
  endtask

  task automatic test_reset;
    clr_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (alu_ctl !== 13'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || z_hi !== 32'd0 || z_lo !== 32'd0 ||
        rsp_valid !== 1'b0 || rsp_err !== 1'b0 || op_count !== '0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_outputs: ctl=%h a=%h b=%h z=%h%h v=%b err=%b cnt=%0d rdy=%b want all 0",
                           alu_ctl, alu_a, alu_b, z_hi, z_lo, rsp_valid, rsp_err, op_count, req_ready);
    end
    clr_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || alu_ctl !== 13'd0) begin
      failures++; $display("FAIL reset_release: req_ready=%b alu_ctl=%h want 1/000", req_ready, alu_ctl);
    end
    model_cnt = 0;
    $display("reset released req_ready=%b", req_ready);
  endtask

  // Vectors with spelled-out expected results.
  task automatic test_spec_vectors;
    logic [3:0]  t_op[6]  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd14, 4'd5};
    logic [31:0] t_a[6]   = '{32'd5, 32'd3, 32'h10000, 32'd9, 32'd1, 32'd100};
    logic [31:0] t_b[6]   = '{32'd7, 32'd5, 32'h10000, 32'd0, 32'd2, 32'd7};
    logic [63:0] t_z[6]   = '{64'd12, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1_0000_0000, 64'd0, 64'd0, {32'd2, 32'd14}};
    logic        t_err[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          t_lat[6] = '{1, 1, 3, 2, 0, 2};
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.z = t_z[i]; e.err = t_err[i]; e.lat = t_lat[i];
      e.ctl = (t_op[i] > 4'd12) ? 13'd0 : (13'd1 << t_op[i]);
      sb_q.push_back(e);
      run_and_check("spec", t_op[i], t_a[i], t_b[i], 1'b0);
    end
  endtask

  task automatic test_random_ops;
    for (int i = 0; i < 10; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = (i == 3) ? 32'd0 : $urandom();
      sb_q.push_back(make_exp(op, a, b));
      // Raising rsp_ready before the response exists must change nothing.
      if (i % 2 == 1) rsp_ready = 1'b1;
      run_and_check("rand", op, a, b, 1'b0);
    end
  endtask

  task automatic test_hold;
    bit          to;
    int          cyc;
    logic [63:0] z0;
    logic        e0;
    exp_t        e;
    sb_q.push_back(make_exp(4'd1, 32'hF0F0_0000, 32'h0000_0F0F));
    send_req(4'd1, 32'hF0F0_0000, 32'h0000_0F0F, to);
    wait_rsp(cyc, to);
    checks++;
    if (to) begin failures++; $display("FAIL hold rsp_timeout: rsp_valid never high"); end
    z0 = {z_hi, z_lo};
    e0 = rsp_err;
    req_op = 4'd2; req_a = 32'h1234; req_b = 32'h1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || {z_hi, z_lo} !== z0 || rsp_err !== e0 || req_ready !== 1'b0 || alu_a !== 32'hF0F0_0000) begin
        failures++; $display("FAIL hold cycle%0d: v=%b z=%h err=%b rdy=%b alu_a=%h want 1/%h/%b/0/f0f00000",
                             i, rsp_valid, {z_hi, z_lo}, rsp_err, req_ready, alu_a, z0, e0);
      end
    end
    req_valid = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (z0 !== e.z || e0 !== e.err) begin
      failures++; $display("FAIL hold result: got z=%h err=%b want z=%h err=%b", z0, e0, e.z, e.err);
    end
    finish_rsp(1'b0);
    checks++;
    if (op_count !== CNT_W'(model_cnt) || alu_a !== 32'hF0F0_0000) begin
      failures++; $display("FAIL hold after: op_count=%0d alu_a=%h want %0d/f0f00000", op_count, alu_a, model_cnt);
    end
    $display("hold z=%h err=%b count=%0d", z0, e0, op_count);
  endtask

  task automatic test_reset_mid_op;
    bit to;
    int seen;
    send_req(4'd4, 32'd3, 32'd4, to);
    checks++;
    if (alu_ctl !== 13'h010) begin
      failures++; $display("FAIL midrst strobe_before: alu_ctl=%h want 010", alu_ctl);
    end
    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    checks++;
    if (alu_ctl !== 13'd0 || rsp_valid !== 1'b0 || op_count !== '0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL midrst async: ctl=%h v=%b cnt=%0d rdy=%b want 000/0/0/0", alu_ctl, rsp_valid, op_count, req_ready);
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    model_cnt = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || op_count !== '0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL midrst after: rsp_valid_cycles=%0d cnt=%0d rdy=%b want 0/0/1", seen, op_count, req_ready);
    end
    $display("reset mid-op discarded, count=%0d", op_count);
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sb_q.push_back(make_exp(4'd11, 32'(i * 3), 32'd0));
      run_and_check("not", 4'd11, 32'(i * 3), 32'd0, 1'b1);
    end
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== CNT_W'(1)) begin
      failures++; $display("FAIL wrap op_count: got %0d want 1", op_count);
    end
    checks++;
    if (bad_ctl !== 0) begin
      failures++; $display("FAIL onehot alu_ctl: non-one-hot cycles=%0d want 0", bad_ctl);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random_ops();
    test_hold();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
